// File: rtl/write_back_pipe_pkg.sv
// Shared write-back encodings: value-source types and load funct3 codes.
package write_back_pipe_pkg;

  typedef enum logic [1:0] {
    WB_NORMAL = 2'd0,
    WB_LOAD   = 2'd1,
    WB_JAL    = 2'd2,
    WB_HICCUP = 2'd3
  } wb_type_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/write_back_pipe_if.sv
// Write-back pipe bus: entry sources, forwarding queries/results and retire port.
interface write_back_pipe_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic [1:0]      write_back_type;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] memory_read_output;
  logic [XLEN-1:0] execute_result;
  logic [RAW-1:0]  write_back_register_input;
  logic [2:0]      load_funct3;
  logic [1:0]      load_addr_lo;
  logic [RAW-1:0]  query_rs1;
  logic [RAW-1:0]  query_rs2;
  logic            fwd_rs1_hit;
  logic            fwd_rs2_hit;
  logic [XLEN-1:0] fwd_rs1_value;
  logic [XLEN-1:0] fwd_rs2_value;
  logic [XLEN-1:0] write_back_value;
  logic [RAW-1:0]  write_back_register_output;
  logic            write_back_enable;

  modport master (
    output write_back_type, pc, memory_read_output, execute_result,
           write_back_register_input, load_funct3, load_addr_lo,
           query_rs1, query_rs2,
    input  fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_value, fwd_rs2_value,
           write_back_value, write_back_register_output, write_back_enable
  );

  modport slave (
    input  write_back_type, pc, memory_read_output, execute_result,
           write_back_register_input, load_funct3, load_addr_lo,
           query_rs1, query_rs2,
    output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_value, fwd_rs2_value,
           write_back_value, write_back_register_output, write_back_enable
  );
endinterface

// File: rtl/write_back_pipe_wb_value_select.sv
// Entry value mux. Define WB_LOAD_EXT_EN to align and size/sign-extend load data;
// otherwise load data passes through untouched.
module wb_value_select
  import write_back_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wb_type_e        wb_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] exec_data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] load_data;

`ifdef WB_LOAD_EXT_EN
  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = mem_data >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end
`else
  logic unused_load_cfg;
  assign unused_load_cfg = ^{funct3, addr_lo};
  assign load_data       = mem_data;
`endif

  always_comb begin
    case (wb_type)
      WB_LOAD:   value = load_data;
      WB_JAL:    value = pc + XLEN'(4);
      WB_NORMAL: value = exec_data;
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/write_back_pipe.sv
// Write-back delay line with youngest-first register forwarding.
// Optional load extension via WB_LOAD_EXT_EN (see wb_value_select).
module write_back_pipe
  import write_back_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int RAW   = 5
) (
  input logic clk,
  input logic reset,
  input logic stall,
  input logic flush,
  write_back_pipe_if.slave wb
);

  wb_type_e        entry_type;
  logic [XLEN-1:0] sel_value;
  logic            entry_valid;
  logic [RAW-1:0]  entry_idx;
  logic [XLEN-1:0] entry_val;

  logic            valid_q [DEPTH];
  logic            valid_d [DEPTH];
  logic [RAW-1:0]  idx_q   [DEPTH];
  logic [RAW-1:0]  idx_d   [DEPTH];
  logic [XLEN-1:0] val_q   [DEPTH];
  logic [XLEN-1:0] val_d   [DEPTH];

  assign entry_type = wb_type_e'(wb.write_back_type);

  wb_value_select #(.XLEN(XLEN)) u_sel (
    .wb_type   (entry_type),
    .pc        (wb.pc),
    .mem_data  (wb.memory_read_output),
    .exec_data (wb.execute_result),
    .funct3    (wb.load_funct3),
    .addr_lo   (wb.load_addr_lo),
    .value     (sel_value)
  );

  // Bubbles carry index 0 and value 0 so the retire port needs no extra gating.
  always_comb begin
    entry_valid = (entry_type != WB_HICCUP) && (wb.write_back_register_input != '0) && !flush;
    entry_idx   = entry_valid ? wb.write_back_register_input : '0;
    entry_val   = entry_valid ? sel_value : '0;
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    val_d   = val_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        idx_d[k]   = '0;
        val_d[k]   = '0;
      end
    end else if (!stall) begin
      valid_d[0] = entry_valid;
      idx_d[0]   = entry_idx;
      val_d[0]   = entry_val;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        idx_d[k]   = idx_q[k-1];
        val_d[k]   = val_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        idx_q[k]   <= '0;
        val_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
    end
  end

  // Oldest stage first so younger matches overwrite; entry is youngest of all.
  always_comb begin
    wb.fwd_rs1_hit   = 1'b0;
    wb.fwd_rs1_value = '0;
    wb.fwd_rs2_hit   = 1'b0;
    wb.fwd_rs2_value = '0;
    if (!reset) begin
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (valid_q[k] && idx_q[k] == wb.query_rs1) begin
          wb.fwd_rs1_hit   = 1'b1;
          wb.fwd_rs1_value = val_q[k];
        end
        if (valid_q[k] && idx_q[k] == wb.query_rs2) begin
          wb.fwd_rs2_hit   = 1'b1;
          wb.fwd_rs2_value = val_q[k];
        end
      end
    end
    if (entry_valid && entry_idx == wb.query_rs1) begin
      wb.fwd_rs1_hit   = 1'b1;
      wb.fwd_rs1_value = entry_val;
    end
    if (entry_valid && entry_idx == wb.query_rs2) begin
      wb.fwd_rs2_hit   = 1'b1;
      wb.fwd_rs2_value = entry_val;
    end
    if (wb.query_rs1 == '0) begin
      wb.fwd_rs1_hit   = 1'b0;
      wb.fwd_rs1_value = '0;
    end
    if (wb.query_rs2 == '0) begin
      wb.fwd_rs2_hit   = 1'b0;
      wb.fwd_rs2_value = '0;
    end
  end

  assign wb.write_back_enable          = valid_q[DEPTH-1];
  assign wb.write_back_register_output = idx_q[DEPTH-1];
  assign wb.write_back_value           = val_q[DEPTH-1];

endmodule

// File: doc/write_back_pipe.md
WRITE_BACK_PIPE -- requirements
Module: write_back_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of all value paths.
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages between entry and retire (legal 1..8).
REQ-003 SHALL have parameter RAW, default 5, register-index width.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: stall  in  1  hold all stages; flush  in  1  squash all in-flight entries.
REQ-007 SHALL have ports: write_back_type  in  2  WB_NORMAL/WB_LOAD/WB_JAL/WB_HICCUP.
REQ-008 SHALL have ports: pc, memory_read_output, execute_result  in  XLEN each  value sources.
REQ-009 SHALL have ports: write_back_register_input  in  RAW  destination index.
REQ-010 SHALL have ports: load_funct3  in  3, load_addr_lo  in  2  load size/sign and byte offset.
REQ-011 SHALL have ports: query_rs1, query_rs2  in  RAW  forwarding lookups.
REQ-012 SHALL have ports: fwd_rs1_hit, fwd_rs2_hit  out  1; fwd_rs1_value, fwd_rs2_value  out  XLEN.
REQ-013 SHALL have ports: write_back_value  out  XLEN; write_back_register_output  out  RAW; write_back_enable  out  1.

Function
REQ-014 Entry value SHALL be: WB_LOAD -> load data, WB_JAL -> pc+4 (mod 2^XLEN), WB_NORMAL -> execute_result, WB_HICCUP -> 0.
REQ-015 Entry SHALL be a bubble (valid=0, index 0, value 0) when type is WB_HICCUP, index is 0, or flush=1.
REQ-016 Each cycle with stall=0, entry SHALL shift into stage 1 and stage k into stage k+1; stage DEPTH drives outputs; latency exactly DEPTH cycles.
REQ-017 With stall=1 and flush=0, all stages and outputs SHALL hold; entry is not captured.
REQ-018 flush=1 SHALL clear every stage to bubble on that edge, overriding stall.
REQ-019 write_back_enable SHALL equal stage DEPTH valid; with enable=0 index and value SHALL read 0.
REQ-020 Forwarding SHALL search entry (combinational) then stages 1..DEPTH; youngest valid match wins.
REQ-021 Query index 0 SHALL never hit; bubbles SHALL never hit; on miss value SHALL be 0.
REQ-022 Forwarding outputs SHALL be purely combinational from current stage contents and inputs.
REQ-023 Stage DEPTH SHALL still be searched while its value is on the outputs (register file write not yet visible).

Reset
REQ-024 reset=1 at a rising edge SHALL clear all stages to bubble and outputs to 0/0/0, overriding stall and flush.
REQ-025 During reset, forward hits SHALL reflect only the combinational entry path.

Configuration
REQ-026 With WB_LOAD_EXT_EN defined, load data SHALL be memory_read_output shifted right by 8*load_addr_lo, then per load_funct3: 000 LB sign-extend 8, 001 LH sign-extend 16, 010 LW full, 100 LBU zero-extend 8, 101 LHU zero-extend 16, other -> full word.
REQ-027 Without WB_LOAD_EXT_EN, load data SHALL be memory_read_output unmodified; load_funct3 and load_addr_lo ignored.

Structure
REQ-028 WB_* type encodings and load funct3 codes SHALL live in the shared format package/header, not locally.
REQ-029 Value selection plus load extension SHALL be one sub-module, wb_value_select; the stage array and forward search stay in write_back_pipe.

Verification
REQ-030 DEPTH=2, WB_NORMAL, idx 5, execute_result 0x1234 -> enable=1, idx 5, value 0x1234 exactly two edges later.
REQ-031 WB_JAL pc=0xFFFFFFFC idx 1 -> retired value 0x00000000; WB_HICCUP idx 7 -> enable=0, no forward hit.
REQ-032 Idx 3 written 0xA then 0xB next cycle, query_rs1=3 -> hit value 0xB (youngest); query 0 -> no hit.
REQ-033 Entry in flight, stall=1 for 3 cycles -> outputs frozen, retire delayed 3 cycles; flush with stall -> all bubbles next edge.
REQ-034 WB_LOAD_EXT_EN, mem 0x80FF7F01, addr_lo 2, LB -> 0xFFFFFFFF; LHU addr_lo 2 -> 0x000080FF; without macro -> 0x80FF7F01.
REQ-035 reset asserted mid-stream -> next edge outputs 0/0/0, no stale entry retires afterwards.
